// File: rtl/sb_uart_pkg.sv
// rtl/sb_uart_pkg.sv - shared types and constants for the UART TX scheduler
// Purpose: FSM state encoding, default message geometry and a small helper.
// Ports: none (package).
package sb_uart_pkg;

  localparam int MAX_BYTES = 16;
  localparam int STR_W     = 8 * MAX_BYTES;
  localparam int LEN_W     = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    KICK      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// rtl/sb_rr_arbiter.sv - round-robin winner selection with latched result
// Purpose: picks the first set request at or after the rotation pointer
//   (wrapping) and holds that choice from one advance strobe to the next.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   i_req      - request vector
//   i_ptr      - round-robin pointer (0..N_REQ-1)
//   i_advance  - latch a new winner this cycle
//   o_win      - latched winner index
//   o_valid    - latched winner is a real request
module sb_rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_win,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_pick;
  logic               r_valid;
  logic [IDX_W-1:0]   r_win;

  // Rotate so that bit 0 of w_rot is the requester under the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N_REQ'(w_dbl >> i_ptr);

  always_comb begin
    w_off = '0;
    // Scan downwards so the lowest set offset wins.
    for (int p = N_REQ - 1; p >= 0; p--) begin
      if (w_rot[p]) w_off = IDX_W'(p);
    end
  end

  // Undo the rotation: (ptr + offset) mod N_REQ.
  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(N_REQ)) w_sum = w_sum - (IDX_W + 1)'(N_REQ);
    w_pick = w_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win   <= '0;
      r_valid <= 1'b0;
    end else if (i_advance) begin
      r_win   <= w_pick;
      r_valid <= |i_req;
    end
  end

  assign o_win   = r_win;
  assign o_valid = r_valid;

endmodule

// File: rtl/sb_uart_tx_scheduler.sv
// rtl/sb_uart_tx_scheduler.sv - round-robin sharing of one UART transmitter
// Purpose: arbitrates N_REQ requesters, snapshots the winning message,
//   kicks the UART once, watches its done handshake with watchdogs and
//   enforces an idle gap between messages.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req/req_len/req_str   - per-requester level request, length, message
//   grant, complete       - one-hot single-cycle pulses per requester
//   uart_transmit         - single-cycle start pulse to the UART
//   uart_str_len/uart_str - latched message towards the UART
//   uart_done             - UART done flag, low while sending
//   busy, timeout_err     - not idle; sticky watchdog expiry flag
module sb_uart_tx_scheduler
  import sb_uart_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MAX_BYTES   = 16,
  parameter int ACK_CYC     = 1024,
  parameter int TIMEOUT_CYC = 200000,
  parameter int GAP_CYC     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [8*N_REQ-1:0]           req_len,
  input  logic [8*MAX_BYTES*N_REQ-1:0] req_str,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             complete,
  output logic                         uart_transmit,
  output logic [LEN_W-1:0]             uart_str_len,
  output logic [8*MAX_BYTES-1:0]       uart_str,
  input  logic                         uart_done,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int SW    = 8 * MAX_BYTES;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(ACK_CYC, TIMEOUT_CYC)) + 1;

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  // GAP lasts GAP_CYC+1 cycles so busy drops GAP_CYC+1 cycles after complete.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC);

  state_t            r_state;
  logic [IDX_W-1:0]  r_rr;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_complete;
  logic              r_transmit;
  logic [LEN_W-1:0]  r_len;
  logic [SW-1:0]     r_str;
  logic              r_err;

  logic              w_adv;
  logic [IDX_W-1:0]  w_win;
  logic              w_win_valid;
  logic [N_REQ-1:0]  w_win_oh;
  logic [LEN_W-1:0]  w_len_raw;
  logic [LEN_W-1:0]  w_len_clamp;
  logic [SW-1:0]     w_str_sel;
  logic [IDX_W-1:0]  w_rr_next;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_adv = (r_state == IDLE) && (|req);

  // Winner stays latched in the arbiter for the whole message, since the
  // arbiter only advances in IDLE.
  sb_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_ptr     (r_rr),
    .i_advance (w_adv),
    .o_win     (w_win),
    .o_valid   (w_win_valid)
  );

  assign w_win_oh    = N_REQ'(1) << w_win;
  assign w_len_raw   = req_len[int'(w_win)*8 +: 8];
  assign w_str_sel   = req_str[int'(w_win)*SW +: SW];
  assign w_len_clamp = (w_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_raw;
  assign w_rr_next   = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr       <= '0;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_complete <= '0;
      r_transmit <= 1'b0;
      r_len      <= '0;
      r_str      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_grant    <= '0;
      r_complete <= '0;
      r_transmit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_adv) r_state <= LOAD;
        end
        LOAD: begin
          r_cnt <= '0;
          if (!w_win_valid) begin
            r_state <= IDLE;
          end else begin
            r_grant <= w_win_oh;
            r_str   <= w_str_sel;
            r_len   <= w_len_clamp;
            r_rr    <= w_rr_next;
            if (w_len_raw == '0) begin
              // Empty message: finish immediately, the UART is never touched.
              r_complete <= w_win_oh;
              r_state    <= GAP;
            end else begin
              r_state <= KICK;
            end
          end
        end
        KICK: begin
          r_transmit <= 1'b1;
          r_cnt      <= '0;
          r_state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!uart_done) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (r_cnt == ACK_LAST) begin
            r_err      <= 1'b1;
            r_complete <= w_win_oh;
            r_cnt      <= '0;
            r_state    <= GAP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (uart_done) begin
            r_complete <= w_win_oh;
            r_cnt      <= '0;
            r_state    <= GAP;
          end else if (r_cnt == TO_LAST) begin
            r_err      <= 1'b1;
            r_complete <= w_win_oh;
            r_cnt      <= '0;
            r_state    <= GAP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant         = r_grant;
  assign complete      = r_complete;
  assign uart_transmit = r_transmit;
  assign uart_str_len  = r_len;
  assign uart_str      = r_str;
  assign busy          = (r_state != IDLE);
  assign timeout_err   = r_err;

endmodule

// File: tb/tb_sb_uart_tx_scheduler.sv
// tb/tb_sb_uart_tx_scheduler.sv - self-checking bench for sb_uart_tx_scheduler
module tb_sb_uart_tx_scheduler;

  localparam int N   = 3;
  localparam int ACK = 20;
  localparam int TO  = 200;
  localparam int GAP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_len;
  logic [128*N-1:0] req_str;
  logic [N-1:0]   grant, complete;
  logic           uart_transmit;
  logic [7:0]     uart_str_len;
  logic [127:0]   uart_str;
  logic           uart_done;
  logic           busy, timeout_err;

  logic [7:0]   lens [N];
  logic [127:0] strs [N];

  assign req_len = {lens[2], lens[1], lens[0]};
  assign req_str = {strs[2], strs[1], strs[0]};

  sb_uart_tx_scheduler #(
    .N_REQ(N), .MAX_BYTES(16), .ACK_CYC(ACK), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_str(req_str),
    .grant(grant), .complete(complete), .uart_transmit(uart_transmit),
    .uart_str_len(uart_str_len), .uart_str(uart_str), .uart_done(uart_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  // UART model: mode 0 normal, 1 never drops done, 2 drops but never raises.
  int   mode = 0;
  bit   model_kill = 1'b0;
  int   n_tx = 0;
  int   cyc, drop_at, rise_at;

  initial begin
    uart_done = 1'b1;
    cyc = 0; drop_at = -1; rise_at = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (model_kill) begin
        drop_at = -1; rise_at = -1; uart_done = 1'b1;
      end else begin
        if (uart_transmit === 1'b1) begin
          n_tx++;
          if (mode != 1) drop_at = cyc + 3;
        end
        if (cyc == drop_at) begin
          uart_done = 1'b0;
          drop_at = -1;
          if (mode == 0) rise_at = cyc + 50;
        end
        if (cyc == rise_at) begin
          uart_done = 1'b1;
          rise_at = -1;
        end
      end
    end
  end

  typedef struct {
    logic [2:0]   id;
    logic [7:0]   len;
    logic [127:0] str;
    bit           zero;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k);
    exp_t e;
    e.id   = 3'b001 << k;
    e.len  = (lens[k] > 8'd16) ? 8'd16 : lens[k];
    e.str  = strs[k];
    e.zero = (lens[k] == 8'd0);
    q.push_back(e);
  endtask

  // Waits for a grant (cmpl=0) or complete (cmpl=1) pulse, bounded by budget.
  task automatic wait_sig(input bit cmpl, input int budget, output logic [2:0] v,
                          output int n, output bit grant_seen);
    v = '0; n = 0; grant_seen = 1'b0;
    while (n < budget) begin
      tick();
      n++;
      if (!cmpl && grant != '0) begin
        v = grant;
        return;
      end
      if (cmpl) begin
        if (grant != '0) grant_seen = 1'b1;
        if (complete != '0) begin
          v = complete;
          return;
        end
      end
    end
  endtask

  task automatic expect_grant(input string tag);
    logic [2:0] v; int n; bit gs; exp_t e;
    wait_sig(1'b0, 100, v, n, gs);
    chk({tag, "_sb_depth"}, 128'(q.size() != 0), 128'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_grant"}, v, e.id);
      chk({tag, "_len"}, uart_str_len, e.len);
      chk({tag, "_str"}, uart_str, e.str);
      chk({tag, "_cmpl_at_grant"}, complete, e.zero ? e.id : 3'b000);
    end
  endtask

  task automatic expect_complete(input string tag, input logic [2:0] id,
                                 input int budget, output int n);
    logic [2:0] v; bit gs;
    wait_sig(1'b1, budget, v, n, gs);
    chk({tag, "_complete"}, v, id);
    chk({tag, "_serial"}, gs, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 3'b000);
    chk({tag, "_complete"}, complete, 3'b000);
    chk({tag, "_transmit"}, uart_transmit, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, timeout_err, 1'b0);
    chk({tag, "_len"}, uart_str_len, 8'd0);
    chk({tag, "_str"}, uart_str, 128'd0);
  endtask

  initial begin
    int n;
    int tx0;
    lens[0] = 8'd3;  strs[0] = 128'h00_41_42_43;
    lens[1] = 8'd4;  strs[1] = 128'h44_45_46_47;
    lens[2] = 8'd6;  strs[2] = 128'h48_49_4A_4B_4C_4D;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // All requesting: round-robin order 001, 010, 100, 001
    req = 3'b111;
    push(0); push(1); push(2); push(0);
    for (int m = 0; m < 4; m++) begin
      logic [2:0] id;
      id = q[0].id;
      expect_grant("rr");
      if (m == 3) req = '0;
      expect_complete("rr", id, 200, n);
    end
    wait_idle("rr");

    // Single request with exact latency
    lens[0] = 8'd5; strs[0] = 128'("HELLO");
    req = 3'b001; push(0);
    tick(); chk("single_grant_early", grant, 3'b000);
    tick();
    chk("single_grant_lat", grant, 3'b001);
    chk("single_len", uart_str_len, 8'd5);
    chk("single_str", uart_str, 128'("HELLO"));
    void'(q.pop_front());
    req = '0;
    tick(); chk("single_tx_lat", uart_transmit, 1'b1);
    expect_complete("single", 3'b001, 200, n);
    chk("single_len_held", uart_str_len, 8'd5);
    chk("single_str_held", uart_str, 128'("HELLO"));
    chk("single_err", timeout_err, 1'b0);
    repeat (GAP) tick();
    chk("single_busy_gap", busy, 1'b1);
    tick();
    chk("single_busy_low", busy, 1'b0);

    // Zero length
    lens[1] = 8'd0;
    tx0 = n_tx;
    req = 3'b010; push(1);
    expect_grant("zero");
    req = '0;
    wait_idle("zero");
    chk("zero_no_tx", n_tx - tx0, 0);

    // Over length clamp
    lens[2] = 8'd20;
    tx0 = n_tx;
    req = 3'b100; push(2);
    expect_grant("over");
    req = '0;
    expect_complete("over", 3'b100, 200, n);
    chk("over_tx", n_tx - tx0, 1);
    wait_idle("over");

    // Watchdog: done never drops
    mode = 1;
    req = 3'b001; push(0);
    expect_grant("wd_ack");
    req = '0;
    tick(); chk("wd_ack_tx", uart_transmit, 1'b1);
    expect_complete("wd_ack", 3'b001, 100, n);
    chk("wd_ack_cycles", n, ACK);
    chk("wd_ack_err", timeout_err, 1'b1);
    wait_idle("wd_ack");
    mode = 0;
    lens[1] = 8'd4;
    req = 3'b010; push(1);
    expect_grant("wd_next");
    req = '0;
    expect_complete("wd_next", 3'b010, 200, n);
    chk("wd_err_sticky", timeout_err, 1'b1);
    wait_idle("wd_next");

    // Reset mid-transfer
    req = 3'b001; push(0);
    expect_grant("mid");
    req = '0;
    n = 0;
    while (uart_done && n < 50) begin
      tick();
      n++;
    end
    chk("mid_done_low", uart_done, 1'b0);
    tick(); tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1; model_kill = 1'b1; req = 3'b101;
    #1;
    chk_all_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_complete", complete, 3'b000);
    end
    rst = 1'b0; model_kill = 1'b0;
    push(0);
    expect_grant("post_rst");
    req = '0;
    expect_complete("post_rst", 3'b001, 200, n);
    wait_idle("post_rst");

    // Watchdog: done drops but never rises
    mode = 2;
    req = 3'b010; push(1);
    expect_grant("wd_to");
    req = '0;
    tick(); chk("wd_to_tx", uart_transmit, 1'b1);
    chk("wd_to_err_clear", timeout_err, 1'b0);
    expect_complete("wd_to", 3'b010, 300, n);
    chk("wd_to_cycles", 128'(n >= TO && n <= TO + 10), 128'd1);
    chk("wd_to_err", timeout_err, 1'b1);
    model_kill = 1'b1;
    tick();
    model_kill = 1'b0;
    mode = 0;
    wait_idle("wd_to");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
